// File: rtl/if_bus_if.sv
// Instruction-fetch bus interface: zero-latency scratch-pad fetches, and a
// request/grant/ready transaction on the shared bus for everything else.
module if_bus_if #(
    parameter int                ADDR_W   = 30,
    parameter int                DATA_W   = 32,
    parameter logic [2:0]        SPM_PAGE = 3'd1,
    parameter logic [DATA_W-1:0] NOP_INSN = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic [DATA_W-1:0] insn,
    output logic              spm_as,
    output logic [ADDR_W-1:0] spm_addr,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic              bus_req,
    input  logic              bus_grnt,
    output logic              bus_as,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_rdy,
    input  logic [DATA_W-1:0] bus_rd_data
);

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] rd_buf;
    logic              discard;
    logic              spm_hit;
    logic              bus_fetch;
    logic              drop;

    assign spm_hit   = req && (addr[ADDR_W-1:ADDR_W-3] == SPM_PAGE);
    assign bus_fetch = req && !spm_hit;
    assign spm_addr  = addr;
    // A flush seen anywhere during the bus cycle discards the returned word.
    assign drop      = flush || discard;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case can infer a latch.
        next_state = state;
        case (state)
            IDLE:    if (!flush && bus_fetch) next_state = REQ;
            REQ: begin
                if (bus_grnt)   next_state = ACCESS;
                else if (flush) next_state = IDLE;
            end
            ACCESS:  if (bus_rdy) next_state = (stall && !drop) ? STALL : IDLE;
            STALL:   if (!stall || flush) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_req  <= 1'b0;
            bus_as   <= 1'b0;
            bus_addr <= '0;
            rd_buf   <= NOP_INSN;
            discard  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && bus_fetch) begin
                        bus_req  <= 1'b1;
                        bus_addr <= addr;
                    end
                end
                REQ: begin
                    // Grant beats a simultaneous flush; the cycle runs, data is dropped.
                    if (bus_grnt) begin
                        bus_as  <= 1'b1;
                        discard <= flush;
                    end else if (flush) begin
                        bus_req <= 1'b0;
                    end
                end
                ACCESS: begin
                    bus_as <= 1'b0;
                    if (flush) discard <= 1'b1;
                    if (bus_rdy) begin
                        bus_req <= 1'b0;
                        rd_buf  <= bus_rd_data;
                        discard <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy   = 1'b0;
        insn   = NOP_INSN;
        spm_as = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (spm_hit) begin
                            spm_as = 1'b1;
                            insn   = spm_rd_data;
                        end else if (bus_fetch) begin
                            busy = 1'b1;
                        end
                    end
                end
                REQ:    busy = 1'b1;
                ACCESS: begin
                    if (!bus_rdy)   busy = 1'b1;
                    else if (!drop) insn = bus_rd_data;
                end
                STALL:  if (!flush) insn = rd_buf;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_bus_if.sv
// Self-checking bench for if_bus_if: the bench plays the bus arbiter/slave
// and scores fetched instructions through an expected-value queue.
module tb_if_bus_if;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        req;
    logic [29:0] addr;
    logic        busy;
    logic [31:0] insn;
    logic        spm_as;
    logic [29:0] spm_addr;
    logic [31:0] spm_rd_data;
    logic        bus_req;
    logic        bus_grnt;
    logic        bus_as;
    logic [29:0] bus_addr;
    logic        bus_rdy;
    logic [31:0] bus_rd_data;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    if_bus_if dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .req         (req),
        .addr        (addr),
        .busy        (busy),
        .insn        (insn),
        .spm_as      (spm_as),
        .spm_addr    (spm_addr),
        .spm_rd_data (spm_rd_data),
        .bus_req     (bus_req),
        .bus_grnt    (bus_grnt),
        .bus_as      (bus_as),
        .bus_addr    (bus_addr),
        .bus_rdy     (bus_rdy),
        .bus_rd_data (bus_rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_compare(input string tag);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check(tag, insn, e);
    endtask

    task automatic bus_fetch(input string tag, input logic [29:0] a, input logic [31:0] d,
                             input int g_dly, input int r_dly, input bit stall_rdy,
                             input bit flush_acc, input bit flush_grant);
        int pulses;
        pulses = 0;
        next_cycle();
        req = 1'b1; addr = a; flush = 1'b0; stall = 1'b0; bus_grnt = 1'b0; bus_rdy = 1'b0;
        exp_q.push_back((flush_acc || flush_grant) ? NOP : d);
        @(negedge clk);
        check({tag, "_busy_issue"}, 32'(busy), 32'd1);
        check({tag, "_spm_as_issue"}, 32'(spm_as), 32'd0);
        for (int k = 0; k <= g_dly; k++) begin
            next_cycle();
            bus_grnt = (k == g_dly);
            flush    = flush_grant && (k == g_dly);
            @(negedge clk);
            pulses += int'(bus_as);
            check({tag, "_busy_req"}, 32'(busy), 32'd1);
            check({tag, "_bus_req_req"}, 32'(bus_req), 32'd1);
            if (k == 0) check({tag, "_bus_addr"}, 32'(bus_addr), 32'(a));
        end
        for (int k = 0; k <= r_dly; k++) begin
            next_cycle();
            bus_grnt    = 1'b0;
            flush       = flush_acc;
            bus_rdy     = (k == r_dly);
            bus_rd_data = (k == r_dly) ? d : 32'hBAD0_0000 + 32'(k);
            stall       = stall_rdy && (k == r_dly);
            @(negedge clk);
            pulses += int'(bus_as);
            check({tag, "_bus_req_acc"}, 32'(bus_req), 32'd1);
            if (k < r_dly) begin
                check({tag, "_busy_acc"}, 32'(busy), 32'd1);
            end else begin
                check({tag, "_busy_rdy"}, 32'(busy), 32'd0);
                sb_compare({tag, "_insn_rdy"});
            end
        end
        next_cycle();
        req = 1'b0; bus_rdy = 1'b0; flush = 1'b0; stall = stall_rdy;
        @(negedge clk);
        pulses += int'(bus_as);
        check({tag, "_bus_req_done"}, 32'(bus_req), 32'd0);
        check({tag, "_as_once"}, 32'(pulses), 32'd1);
        if (stall_rdy) begin
            for (int s = 0; s < 4; s++) begin
                if (s != 0) next_cycle();
                @(negedge clk);
                check({tag, "_stall_insn"}, insn, d);
                check({tag, "_stall_busy"}, 32'(busy), 32'd0);
            end
            next_cycle();
            stall = 1'b0;
            @(negedge clk);
            check({tag, "_stall_release_insn"}, insn, d);
            next_cycle();
            @(negedge clk);
            check({tag, "_idle_insn"}, insn, NOP);
        end else begin
            check({tag, "_idle_insn"}, insn, NOP);
            check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; req = 1'b1; addr = 30'h0000_0040;
        spm_rd_data = 32'h0; bus_grnt = 1'b0; bus_rdy = 1'b0; bus_rd_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_bus_req", 32'(bus_req), 32'd0);
        check("reset_bus_as", 32'(bus_as), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_insn", insn, NOP);
        next_cycle();
        reset = 1'b1; req = 1'b0;

        // SPM hit, zero latency
        next_cycle();
        req = 1'b1; addr = 30'h0800_0010; spm_rd_data = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        check("spm_as", 32'(spm_as), 32'd1);
        check("spm_busy", 32'(busy), 32'd0);
        check("spm_addr", 32'(spm_addr), 32'h0800_0010);
        sb_compare("spm_insn");
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("spm_bus_req", 32'(bus_req), 32'd0);
        check("spm_flush_as", 32'(spm_as), 32'd0);
        check("spm_flush_insn", insn, NOP);
        next_cycle();
        flush = 1'b0; req = 1'b0;

        bus_fetch("imm",   30'h0000_0044, 32'hCAFE_0001, 0, 0, 1'b0, 1'b0, 1'b0);
        bus_fetch("slow",  30'h0000_0040, 32'h1234_5678, 2, 3, 1'b0, 1'b0, 1'b0);
        bus_fetch("stall", 30'h0000_0040, 32'h1234_5678, 2, 3, 1'b1, 1'b0, 1'b0);

        // Flush in REQ with no grant withdraws the request
        next_cycle();
        req = 1'b1; addr = 30'h0000_0080;
        @(negedge clk);
        check("flreq_busy_issue", 32'(busy), 32'd1);
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("flreq_bus_req_req", 32'(bus_req), 32'd1);
        check("flreq_insn_req", insn, NOP);
        next_cycle();
        flush = 1'b0; req = 1'b0;
        @(negedge clk);
        check("flreq_bus_req_drop", 32'(bus_req), 32'd0);
        check("flreq_busy_idle", 32'(busy), 32'd0);
        check("flreq_insn_idle", insn, NOP);

        bus_fetch("flacc", 30'h0000_0048, 32'hAAAA_5555, 1, 2, 1'b0, 1'b1, 1'b0);
        bus_fetch("flgnt", 30'h0000_004C, 32'h5555_AAAA, 1, 1, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a bus cycle
        next_cycle();
        req = 1'b1; addr = 30'h0000_0050;
        next_cycle();
        bus_grnt = 1'b1;
        next_cycle();
        bus_grnt = 1'b0;
        @(negedge clk);
        check("rstmid_bus_as", 32'(bus_as), 32'd1);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 32'(busy), 32'd0);
        next_cycle();
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        check("rstmid_bus_req", 32'(bus_req), 32'd0);
        check("rstmid_bus_as_off", 32'(bus_as), 32'd0);
        check("rstmid_insn", insn, NOP);

        bus_fetch("post",  30'h0000_0060, 32'h0BAD_F00D, 1, 1, 1'b0, 1'b0, 1'b0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_bus_if.md
# if_bus_if

Instruction-fetch bus interface that sits directly upstream of the IF pipeline register. It takes the current fetch PC and returns the instruction word to be latched into IF/ID. Fetches that hit the scratch-pad memory (SPM) complete in the same cycle. All other fetches run a request/grant/ready transaction on the shared system bus. While a bus fetch is in progress the block raises `busy`, which pipeline control turns into the IF stall.

## Interface
Parameters:
- `ADDR_W`, 30: word-address width (PC width).
- `DATA_W`, 32: instruction width.
- `SPM_PAGE`, 3'd1: value of `addr[ADDR_W-1:ADDR_W-3]` that selects SPM.
- `NOP_INSN`, 32'h0000_0000: ISA NOP encoding, returned on flush, idle or reset.

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the rising `clk` edge; a low level resets the block.
- `stall` in 1: global pipeline stall.
- `flush` in 1: pipeline flush.
- `req` in 1: fetch request valid.
- `addr` in ADDR_W: fetch word address (PC).
- `busy` out 1: fetch not complete; IF must stall.
- `insn` out DATA_W: fetched instruction, to the IF register.
- `spm_as` out 1: SPM read strobe.
- `spm_addr` out ADDR_W: SPM address.
- `spm_rd_data` in DATA_W: SPM read data (combinational read).
- `bus_req` out 1: bus request to the arbiter.
- `bus_grnt` in 1: bus grant.
- `bus_as` out 1: bus address strobe.
- `bus_addr` out ADDR_W: bus address.
- `bus_rdy` in 1: bus slave ready.
- `bus_rd_data` in DATA_W: bus read data.

## Operation
- An SPM hit is `req && addr[ADDR_W-1:ADDR_W-3]==SPM_PAGE`. Any other `req` is a bus fetch.
- State machine: IDLE, REQ, ACCESS, STALL. State is registered.
- Registered signals: `bus_req`, `bus_as`, `bus_addr`, read buffer `rd_buf`.
- Combinational outputs: `busy`, `insn`, `spm_as`, `spm_addr`.
- `spm_addr` = `addr` in every state.
- IDLE:
  - If `flush`: `insn`=NOP, `busy`=0, no access.
  - SPM hit: `spm_as`=1, `insn`=`spm_rd_data`, `busy`=0, stay in IDLE.
  - Bus fetch: `busy`=1. Next edge: `bus_req`<=1, `bus_addr`<=`addr`, go to REQ.
  - No `req`: `insn`=NOP, `busy`=0.
- REQ:
  - `busy`=1.
  - If `flush` and not `bus_grnt`: `bus_req`<=0, go to IDLE (request withdrawn).
  - Else if `bus_grnt`: `bus_as`<=1, go to ACCESS.
- ACCESS:
  - `bus_as`<=0 after one cycle.
  - While not `bus_rdy`: `busy`=1.
  - On `bus_rdy`: `bus_req`<=0, `rd_buf`<=`bus_rd_data`, `busy`=0, `insn`=`bus_rd_data`.
  - Next state after `bus_rdy`: STALL if `stall`, else IDLE.
  - `flush` in ACCESS does not abort the bus cycle. Wait for `bus_rdy`, discard the data, drive `insn`=NOP and `busy`=0, then go to IDLE.
- STALL:
  - `insn`=`rd_buf`, `busy`=0.
  - When `stall`=0: go to IDLE.
  - `flush` in STALL: `insn`=NOP, go to IDLE.
- `flush` overrides `insn` to NOP in every state.
- `bus_req` stays high from REQ entry through the `bus_rdy` cycle, so ownership is held for exactly one transfer.

## Timing
- Reset (`reset`=0 at a rising edge) sets:
  - state=IDLE, `bus_req`=0, `bus_as`=0, `bus_addr`=0, `rd_buf`=NOP.
  - Resulting outputs: `busy`=0, `insn`=NOP, `spm_as`=0.
- Reset mid-transaction drops `bus_req` and `bus_as` on that edge with no completion.
- SPM fetch latency is 0 cycles: `insn` is valid in the request cycle.
- Bus fetch with immediate grant and ready: request in cycle 0, REQ in cycle 1, ACCESS in cycle 2 with `bus_rdy`. `busy` is high in cycles 0–1 and low in cycle 2.
- `bus_as` is high for exactly one cycle per transfer.
- `req` and `addr` must be held stable while `busy`=1. IF is stalled during this time, so the PC does not change.
- Simultaneous `flush` and `bus_grnt` in REQ: the grant wins. Go to ACCESS, complete the cycle, discard the data.

## Test plan
- Reset: drive `reset`=0 for 2 edges with `req`=1 and a bus address. Required: `bus_req`=0, `bus_as`=0, `busy`=0, `insn`=NOP.
- SPM hit: `addr`=30'h0800_0010 (page 1), `spm_rd_data`=32'hDEAD_BEEF. Required in the same cycle: `spm_as`=1, `insn`=32'hDEAD_BEEF, `busy`=0, `bus_req` stays 0.
- Bus fetch with 2-cycle grant delay and 3-cycle ready delay: `addr`=30'h0000_0040, `bus_rd_data`=32'h1234_5678. Required:
  - `bus_addr`=30'h40.
  - `bus_as` pulses exactly once.
  - `busy` high until the `bus_rdy` cycle.
  - `insn`=32'h1234_5678 in the `bus_rdy` cycle.
  - `bus_req` low on the next edge.
- Stall after completion: `stall`=1 during the `bus_rdy` cycle and held 4 cycles. Required: state STALL, `insn`=32'h1234_5678 held all 4 cycles, `busy`=0; state returns to IDLE one edge after `stall` falls.
- Flush in REQ (no grant). Required: `bus_req` falls next edge, `insn`=NOP, `busy`=0 after return to IDLE.
- Flush in ACCESS. Required: `bus_req` held until `bus_rdy`, `insn`=NOP in the `bus_rdy` cycle, then state IDLE.
